// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg
// Shared constants for the 7-segment scan driver: the segment bus width,
// the segment bit order (bit 6 = a ... bit 0 = g, active-high), the blank
// pattern, and the width helper used to size the digit index.
package seg7_scan_driver_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_BLANK = '0;

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
// Bundles the pattern/load inputs and the scanned display outputs.
//   seg_in     : NUM_DIGITS packed 7-bit patterns, digit k at [7k+6:7k]
//   load       : one-cycle strobe capturing seg_in into the pending buffer
//   digit_en   : live per-digit enable (0 blanks that digit's slot)
//   seg_out    : shared segment bus, active-high
//   dig_sel    : one-hot active-low digit select
//   pending    : captured data waiting for a frame boundary
//   frame_done : one-cycle pulse after the last slot of a frame
// master = pattern source, slave = scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_scan_driver_pkg::*;

    logic [SEG_W*NUM_DIGITS-1:0] seg_in;
    logic                        load;
    logic [NUM_DIGITS-1:0]       digit_en;
    logic [SEG_W-1:0]            seg_out;
    logic [NUM_DIGITS-1:0]       dig_sel;
    logic                        pending;
    logic                        frame_done;

    modport master (
        output seg_in, load, digit_en,
        input  seg_out, dig_sel, pending, frame_done
    );

    modport slave (
        input  seg_in, load, digit_en,
        output seg_out, dig_sel, pending, frame_done
    );

endinterface

// File: rtl/seg7_scan_prescaler.sv
// seg7_scan_prescaler
// Slot timer for the scan driver. Counts 0..CLK_DIV-1 and raises tick on the
// last count of each slot. dead flags the first DEAD_CYCLES counts of a slot
// when the DEAD_TIME_EN macro is defined, and is held 0 otherwise.
// Ports: clk, rst_n (sync, active-low), tick, dead.
module seg7_scan_prescaler #(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic dead
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

`ifdef DEAD_TIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    logic [PW-1:0] cnt;

    assign tick = (cnt == PW'(CLK_DIV - 1));
    assign dead = DEAD_EN && (int'(cnt) < DEAD_CYCLES);

    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes NUM_DIGITS segment patterns onto one segment bus with
// one-hot active-low digit selects. Loaded patterns sit in a pending buffer
// and move to the display buffer only at a frame boundary, so a frame is
// never drawn from mixed data. Optional anti-ghosting blanking at the start
// of each slot is enabled with the DEAD_TIME_EN macro.
// Ports: clk, rst_n (sync, active-low), bus (seg7_scan_driver_if.slave).
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    bus
);

    localparam int IW = clog2(NUM_DIGITS);

    logic                              tick;
    logic                              dead;
    logic                              boundary;
    logic [IW-1:0]                     idx;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]  display;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]  pend_buf;
    logic                              pend_q;

    seg7_scan_prescaler #(
        .CLK_DIV     (CLK_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .dead  (dead)
    );

    assign boundary    = tick && (idx == IW'(NUM_DIGITS - 1));
    assign bus.pending = pend_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx            <= '0;
            display        <= '0;
            pend_buf       <= '0;
            pend_q         <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.seg_out    <= SEG_BLANK;
            bus.dig_sel    <= '1;
        end else begin
            if (tick) idx <= boundary ? '0 : idx + 1'b1;

            // Old pending data moves out before a coincident load refills
            // the buffer, so a load on the boundary lands one frame later.
            if (boundary && pend_q) display <= pend_buf;

            if (bus.load) begin
                pend_buf <= bus.seg_in;
                pend_q   <= 1'b1;
            end else if (boundary) begin
                pend_q   <= 1'b0;
            end

            bus.frame_done <= boundary;
            bus.dig_sel    <= dead ? '1 : ~(NUM_DIGITS'(1) << idx);
            bus.seg_out    <= (dead || !bus.digit_en[idx]) ? SEG_BLANK : display[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed + randomized bench for seg7_scan_driver (NUM_DIGITS=4, CLK_DIV=4,
// DEAD_CYCLES=1). Expected outputs come from a frame/slot model computed from
// the count of clocks since reset; blanking follows DEAD_TIME_EN.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int CD = 4;
    localparam int DC = 1;
    localparam int FRAME = ND * CD;

`ifdef DEAD_TIME_EN
    localparam bit DEAD = 1'b1;
`else
    localparam bit DEAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (CD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: what is on the glass this frame, what is waiting,
    // and how many clocks have elapsed since reset released.
    logic [6:0] m_disp [ND];
    logic [6:0] m_pbuf [ND];
    bit         m_pend;
    int         c;
    logic [3:0] en_cur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            m_disp[k] = '0;
            m_pbuf[k] = '0;
        end
        m_pend = 1'b0;
        c = 0;
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit rst, input bit ld, input logic [27:0] sin, input logic [3:0] en);
        int slot, pos;
        bit dd, bnd;
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        bit e_fd;
        rst_n        = !rst;
        bus.load     = ld;
        bus.seg_in   = sin;
        bus.digit_en = en;
        @(posedge clk);
        #1;
        if (rst) begin
            e_sel = 4'hF;
            e_seg = 7'h00;
            e_fd  = 1'b0;
            model_reset();
        end else begin
            slot  = (c / CD) % ND;
            pos   = c % CD;
            dd    = DEAD && (pos < DC);
            e_sel = dd ? 4'hF : ~(4'b0001 << slot);
            e_seg = (dd || !en[slot]) ? 7'h00 : m_disp[slot];
            bnd   = (pos == CD - 1) && (slot == ND - 1);
            e_fd  = bnd;
            if (bnd && m_pend) begin
                m_disp = m_pbuf;
                m_pend = 1'b0;
            end
            if (ld) begin
                for (int k = 0; k < ND; k++) m_pbuf[k] = sin[7*k +: 7];
                m_pend = 1'b1;
            end
            c++;
        end
        chk("dig_sel",    32'(bus.dig_sel),    32'(e_sel));
        chk("seg_out",    32'(bus.seg_out),    32'(e_seg));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        chk("pending",    32'(bus.pending),    32'(m_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, en_cur);
    endtask

    // Advance until the next step lands on frame position tgt (bounded).
    task automatic run_to(input int tgt);
        for (int i = 0; i < FRAME && (c % FRAME) != tgt; i++) idle(1);
    endtask

    localparam logic [27:0] P1 = {7'h70, 7'h5B, 7'h6D, 7'h30};
    localparam logic [27:0] PA = {7'h11, 7'h22, 7'h33, 7'h44};
    localparam logic [27:0] PB = {7'h7F, 7'h06, 7'h4F, 7'h66};
    localparam logic [27:0] PC = {7'h3F, 7'h5E, 7'h79, 7'h71};

    initial begin
        logic [27:0] rsin;
        bus.load     = 1'b0;
        bus.seg_in   = '0;
        bus.digit_en = 4'hF;
        en_cur       = 4'hF;
        model_reset();

        // Reset state
        step(1'b1, 1'b0, '0, en_cur);
        step(1'b1, 1'b0, '0, en_cur);

        // First frame after reset: blank data, one frame_done pulse
        idle(FRAME);
        chk("fd_cycle17", 32'(bus.frame_done), 32'd1);

        // Mid-frame load in slot 1; visible only from next frame
        run_to(5);
        step(1'b0, 1'b1, P1, en_cur);
        chk("pend_after_load", 32'(bus.pending), 32'd1);
        run_to(0);
        chk("pend_after_bnd", 32'(bus.pending), 32'd0);
        idle(FRAME);

        // Two loads in one frame: only the second is displayed
        run_to(2);
        step(1'b0, 1'b1, PA, en_cur);
        idle(3);
        step(1'b0, 1'b1, PB, en_cur);
        run_to(0);
        idle(FRAME);

        // Load on the boundary while PA is pending
        run_to(4);
        step(1'b0, 1'b1, PA, en_cur);
        run_to(FRAME - 1);
        step(1'b0, 1'b1, PC, en_cur);
        chk("pend_bnd_load", 32'(bus.pending), 32'd1);
        idle(2 * FRAME);

        // Digit 2 disabled
        en_cur = 4'b1011;
        idle(FRAME);
        en_cur = 4'hF;

        // Reset mid-slot 2 with data pending
        run_to(9);
        step(1'b0, 1'b1, PB, en_cur);
        step(1'b1, 1'b0, '0, en_cur);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        idle(FRAME + 2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) en_cur = 4'($urandom);
            rsin = 28'($urandom);
            step($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0, rsin, en_cur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
